// File: rtl/tribus_pkg.sv
// Shared types and helpers for the tri-state bus scan reader.
package tribus_pkg;

  // Scan sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_TURN   = 3'd4,
    ST_FIN    = 3'd5
  } state_e;

  // All output enables high: every register on the bus is hi-Z.
  // Wide enough for the largest bank; users slice [NREG-1:0].
  localparam logic [15:0] OE_IDLE = 16'hFFFF;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/tribus_oe_decode.sv
// Registered index -> active-low one-hot output-enable decoder.
// When not enabled every bit is high, so no register drives the bus.
// This block is the only source of the OE lines, and its flops reset
// straight to all ones so an abort can never glitch a bit low.
module tribus_oe_decode
  import tribus_pkg::*;
#(
  parameter int NREG = 4,
  parameter int IW   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [IW-1:0]   idx,
  output logic [NREG-1:0] oe
);

  logic [NREG-1:0] oe_d;
  logic [NREG-1:0] oe_q;

  // Pull only the selected enable low; everything else stays released.
  always_comb begin
    oe_d = OE_IDLE[NREG-1:0];
    if (en) oe_d[idx] = 1'b0;
  end

  // Enable register; reset forces every register back to hi-Z.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oe_q <= OE_IDLE[NREG-1:0];
    else        oe_q <= oe_d;
  end

  assign oe = oe_q;

endmodule

// File: rtl/tribus_scan_reader.sv
// Reader for a bank of tri-state registers sharing one bus. A scan
// enables each register in turn, samples the bus, releases it, and
// hands the word downstream over valid/ready. A turnaround gap with
// every enable high separates consecutive drivers.
module tribus_scan_reader
  import tribus_pkg::*;
#(
  parameter int NREG   = 4,
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1,
  parameter int GAP    = 1
) (
  input  logic                   CLK,
  input  logic                   CLR_N,
  input  logic                   START,
  input  logic [WIDTH-1:0]       BUS,
  output logic [NREG-1:0]        OE,
  output logic [WIDTH-1:0]       DOUT,
  output logic [clog2(NREG)-1:0] DIDX,
  output logic                   DVALID,
  input  logic                   DREADY,
  output logic                   BUSY,
  output logic                   DONE
);

  localparam int IW = clog2(NREG);
  localparam int CW = clog2(((SETTLE > GAP) ? SETTLE : GAP) + 1);

  state_e           state_d, state_q;
  logic [IW-1:0]    idx_d, idx_q;
  logic [CW-1:0]    cnt_d, cnt_q;
  logic [WIDTH-1:0] dout_d, dout_q;
  logic [IW-1:0]    didx_d, didx_q;
  logic             dvalid_d, dvalid_q;
  logic             busy_d, busy_q;
  logic             done_d, done_q;
  logic             oe_en;

  // Next-state, counters and output-register updates for the scan sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    didx_d   = didx_q;
    dvalid_d = dvalid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == CW'(SETTLE - 1)) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SAMPLE: begin
        dout_d   = BUS;
        didx_d   = idx_q;
        dvalid_d = 1'b1;
        state_d  = ST_HOLD;
      end
      ST_HOLD: begin
        if (dvalid_q && DREADY) begin
          dvalid_d = 1'b0;
          cnt_d    = '0;
          state_d  = (idx_q == IW'(NREG - 1)) ? ST_FIN : ST_TURN;
        end
      end
      ST_TURN: begin
        if (cnt_q == CW'(GAP - 1)) begin
          cnt_d   = '0;
          idx_d   = idx_q + IW'(1);
          state_d = ST_DRIVE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FIN);
    oe_en  = (state_d == ST_DRIVE) || (state_d == ST_SAMPLE);
  end

  // Sequencer and output registers; reset aborts any scan in progress.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      didx_q   <= '0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      didx_q   <= didx_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // The enable decoder registers the same next state, so OE moves with the FSM.
  tribus_oe_decode #(
    .NREG (NREG),
    .IW   (IW)
  ) u_oe_decode (
    .clk   (CLK),
    .rst_n (CLR_N),
    .en    (oe_en),
    .idx   (idx_d),
    .oe    (OE)
  );

  assign DOUT   = dout_q;
  assign DIDX   = didx_q;
  assign DVALID = dvalid_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_tribus_scan_reader.sv
// Self-checking bench for tribus_scan_reader: bus-side register models,
// a word scoreboard, timing expectations and an OE contention monitor.
module tb_tribus_scan_reader;

  localparam int NREG     = 4;
  localparam int WIDTH    = 4;
  localparam int SETTLE   = 1;
  localparam int GAP      = 1;
  localparam int IW       = 2;
  localparam int FIRST    = SETTLE + 2;
  localparam int PERIOD   = SETTLE + 2 + GAP;
  localparam int BUDGET   = 400;
  localparam int POST     = 6;

  logic             CLK = 1'b0;
  logic             CLR_N = 1'b0;
  logic             START = 1'b0;
  logic             DREADY = 1'b0;
  logic [WIDTH-1:0] BUS;
  logic [NREG-1:0]  OE;
  logic [WIDTH-1:0] DOUT;
  logic [IW-1:0]    DIDX;
  logic             DVALID;
  logic             BUSY;
  logic             DONE;

  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] bus_m;

  int vectors = 0;
  int miscompares = 0;

  int got_idx[$];
  int got_dat[$];
  int got_cyc[$];
  int done_cnt, done_cyc, contention, gap_viol, stall_viol, stall_cycles;
  int busy_after, overlap;
  logic busy_first;
  bit timed_out;

  tribus_scan_reader #(
    .NREG(NREG), .WIDTH(WIDTH), .SETTLE(SETTLE), .GAP(GAP)
  ) dut (
    .CLK(CLK), .CLR_N(CLR_N), .START(START), .BUS(BUS), .OE(OE),
    .DOUT(DOUT), .DIDX(DIDX), .DVALID(DVALID), .DREADY(DREADY),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Tri-state register bank as seen on the shared bus.
  always_comb begin
    int drivers;
    drivers = 0;
    bus_m = 'z;
    for (int i = 0; i < NREG; i++) begin
      if (!OE[i]) begin
        drivers++;
        bus_m = (drivers == 1) ? regs[i] : 'x;
      end
    end
  end
  assign BUS = bus_m;

  // Runs one scan from IDLE and records what the downstream side saw.
  task automatic drive_scan(input int ready_pct, input int stall_idx,
                            input int stall_len, input int poke_cyc);
    int cyc, prev_low, ones_run, lows, low_idx, stall_left;
    bit seen_low;
    logic [WIDTH-1:0] stall_val;
    got_idx.delete(); got_dat.delete(); got_cyc.delete();
    done_cnt = 0; done_cyc = -1; contention = 0; gap_viol = 0;
    stall_viol = 0; stall_cycles = 0; busy_after = 0; overlap = 0;
    busy_first = 1'b0; timed_out = 1'b0;
    prev_low = -1; ones_run = 0; seen_low = 1'b0;
    stall_left = stall_len; stall_val = '0;
    @(negedge CLK);
    START = 1'b1;
    cyc = 0;
    while (cyc < BUDGET && (done_cyc < 0 || cyc < done_cyc + POST)) begin
      @(negedge CLK);
      cyc++;
      START = (cyc == poke_cyc);
      lows = 0; low_idx = -1;
      for (int i = 0; i < NREG; i++) if (!OE[i]) begin lows++; low_idx = i; end
      if (lows > 1) contention++;
      if (lows == 1) begin
        if (prev_low >= 0 && prev_low != low_idx) gap_viol++;
        if (prev_low < 0 && seen_low && ones_run < GAP) gap_viol++;
        prev_low = low_idx; seen_low = 1'b1; ones_run = 0;
      end else if (lows == 0) begin
        prev_low = -1; ones_run++;
      end
      if (cyc == 1) busy_first = BUSY;
      if (DONE) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (DVALID) overlap++;
      end
      if (done_cyc >= 0 && cyc > done_cyc && BUSY) busy_after++;
      if (DVALID && int'(DIDX) == stall_idx && stall_left > 0) begin
        if (stall_left == stall_len) stall_val = DOUT;
        else if (DOUT !== stall_val) stall_viol++;
        if (OE !== {NREG{1'b1}}) stall_viol++;
        stall_left--;
        stall_cycles++;
        DREADY = 1'b0;
      end else begin
        DREADY = ($urandom_range(99, 0) < ready_pct);
      end
      if (DVALID && DREADY) begin
        got_idx.push_back(int'(DIDX));
        got_dat.push_back(int'(DOUT));
        got_cyc.push_back(cyc);
      end
    end
    START = 1'b0;
    DREADY = 1'b0;
    timed_out = (done_cyc < 0);
  endtask

  task automatic test_reset();
    CLR_N = 1'b0; START = 1'b0; DREADY = 1'b0;
    repeat (3) @(negedge CLK);
    vectors++;
    if ({OE, DOUT, DIDX, DVALID, BUSY, DONE} !== {4'hF, 4'h0, 2'd0, 3'b000}) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got OE=%b DOUT=%h DIDX=%0d V=%b B=%b D=%b required 1111/0/0/0/0/0",
               OE, DOUT, DIDX, DVALID, BUSY, DONE);
    end
    CLR_N = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      vectors++;
      if ({OE, DVALID, BUSY} !== {4'hF, 2'b00}) begin
        miscompares++;
        $display("[TB] FAIL idle_cycle%0d: got OE=%b DVALID=%b BUSY=%b required 1111/0/0",
                 c, OE, DVALID, BUSY);
      end
    end
  endtask

  task automatic test_full_scan();
    regs = '{4'hA, 4'h3, 4'hF, 4'h0};
    drive_scan(100, -1, 0, -1);
    vectors++;
    if (busy_first !== 1'b1) begin
      miscompares++; $display("[TB] FAIL full_busy: got %b required 1", busy_first);
    end
    vectors++;
    if (timed_out) begin
      miscompares++; $display("[TB] FAIL full_timeout: got no DONE within %0d cycles", BUDGET);
    end
    vectors++;
    if (got_idx.size() != NREG) begin
      miscompares++; $display("[TB] FAIL full_count: got %0d words required %0d", got_idx.size(), NREG);
    end
    for (int k = 0; k < got_idx.size() && k < NREG; k++) begin
      vectors++;
      if (got_idx[k] != k || got_dat[k] != int'(regs[k]) || got_cyc[k] != FIRST + k * PERIOD) begin
        miscompares++;
        $display("[TB] FAIL full_word%0d: got (%0d,%h)@%0d required (%0d,%h)@%0d",
                 k, got_idx[k], got_dat[k], got_cyc[k], k, regs[k], FIRST + k * PERIOD);
      end
    end
    vectors++;
    if (done_cnt != 1 || done_cyc != FIRST + (NREG - 1) * PERIOD + 1) begin
      miscompares++;
      $display("[TB] FAIL full_done: got %0d pulses @%0d required 1 @%0d",
               done_cnt, done_cyc, FIRST + (NREG - 1) * PERIOD + 1);
    end
    vectors++;
    if (overlap != 0 || busy_after != 0) begin
      miscompares++;
      $display("[TB] FAIL full_tail: got overlap=%0d busy_after=%0d required 0/0", overlap, busy_after);
    end
  endtask

  task automatic test_backpressure();
    int expc;
    int acc;
    regs = '{4'hA, 4'h3, 4'hF, 4'h0};
    drive_scan(100, 1, 7, -1);
    vectors++;
    if (stall_cycles != 7 || stall_viol != 0) begin
      miscompares++;
      $display("[TB] FAIL bp_stall: got %0d stall cycles %0d violations required 7/0", stall_cycles, stall_viol);
    end
    vectors++;
    if (got_idx.size() != NREG || done_cnt != 1 || timed_out) begin
      miscompares++;
      $display("[TB] FAIL bp_count: got %0d words %0d done required %0d/1", got_idx.size(), done_cnt, NREG);
    end
    expc = FIRST;
    for (int k = 0; k < got_idx.size() && k < NREG; k++) begin
      acc = expc + ((k == 1) ? 7 : 0);
      vectors++;
      if (got_idx[k] != k || got_dat[k] != int'(regs[k]) || got_cyc[k] != acc) begin
        miscompares++;
        $display("[TB] FAIL bp_word%0d: got (%0d,%h)@%0d required (%0d,%h)@%0d",
                 k, got_idx[k], got_dat[k], got_cyc[k], k, regs[k], acc);
      end
      expc = acc + PERIOD;
    end
  endtask

  task automatic test_contention();
    int bad;
    for (int s = 0; s < 50; s++) begin
      for (int i = 0; i < NREG; i++) regs[i] = WIDTH'($urandom);
      drive_scan(50, -1, 0, -1);
      vectors++;
      if (contention != 0 || gap_viol != 0) begin
        miscompares++;
        $display("[TB] FAIL cont_oe scan%0d: got %0d overlaps %0d gap errors required 0/0",
                 s, contention, gap_viol);
      end
      vectors++;
      if (timed_out || done_cnt != 1 || overlap != 0) begin
        miscompares++;
        $display("[TB] FAIL cont_done scan%0d: got done=%0d timeout=%0d overlap=%0d required 1/0/0",
                 s, done_cnt, timed_out, overlap);
      end
      bad = (got_idx.size() != NREG) ? 1 : 0;
      for (int k = 0; k < got_idx.size() && k < NREG; k++)
        if (got_idx[k] != k || got_dat[k] != int'(regs[k])) bad++;
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("[TB] FAIL cont_words scan%0d: got %0d words %0d wrong required %0d in order",
                 s, got_idx.size(), bad, NREG);
      end
    end
  endtask

  task automatic test_async_reset();
    int bad;
    for (int i = 0; i < NREG; i++) regs[i] = WIDTH'($urandom);
    DREADY = 1'b1;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    vectors++;
    if (OE !== 4'b1110) begin
      miscompares++; $display("[TB] FAIL ar_drive: got OE=%b required 1110", OE);
    end
    #2 CLR_N = 1'b0;
    #1;
    vectors++;
    if ({OE, DVALID, BUSY} !== {4'hF, 2'b00}) begin
      miscompares++;
      $display("[TB] FAIL ar_abort: got OE=%b DVALID=%b BUSY=%b required 1111/0/0", OE, DVALID, BUSY);
    end
    @(negedge CLK);
    CLR_N = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      vectors++;
      if ({OE, BUSY} !== {4'hF, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL ar_no_resume%0d: got OE=%b BUSY=%b required 1111/0", c, OE, BUSY);
      end
    end
    drive_scan(100, -1, 0, -1);
    bad = (got_idx.size() != NREG || done_cnt != 1) ? 1 : 0;
    for (int k = 0; k < got_idx.size() && k < NREG; k++)
      if (got_idx[k] != k || got_dat[k] != int'(regs[k])) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("[TB] FAIL ar_restart: got %0d words first idx %0d, %0d wrong required %0d from idx 0",
               got_idx.size(), (got_idx.size() > 0) ? got_idx[0] : -1, bad, NREG);
    end
  endtask

  task automatic test_start_ignored();
    int bad;
    for (int i = 0; i < NREG; i++) regs[i] = WIDTH'($urandom);
    drive_scan(100, -1, 0, FIRST + 2 * PERIOD - 1);
    vectors++;
    if (done_cnt != 1 || busy_after != 0 || timed_out) begin
      miscompares++;
      $display("[TB] FAIL si_done: got %0d done, busy after %0d cycles required 1/0", done_cnt, busy_after);
    end
    bad = (got_idx.size() != NREG) ? 1 : 0;
    for (int k = 0; k < got_idx.size() && k < NREG; k++)
      if (got_idx[k] != k || got_dat[k] != int'(regs[k]) || got_cyc[k] != FIRST + k * PERIOD) bad++;
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("[TB] FAIL si_words: got %0d words %0d wrong required %0d in order, undisturbed",
               got_idx.size(), bad, NREG);
    end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) regs[i] = '0;
    test_reset();
    test_full_scan();
    test_backpressure();
    test_contention();
    test_async_reset();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tribus_scan_reader.md
Name: tribus_scan_reader

Overview:
- Bus-side reader for a bank of NREG tri-state output registers that share one WIDTH-bit bus.
- Each register's output enable is active-high-off: OE=1 puts the register in hi-Z; OE=0 drives the bus.
- On a START request, the block enables one register at a time, samples the shared bus, and hands each word downstream over a valid/ready handshake.
- A turnaround gap between enables guarantees no two registers ever drive the bus together.

Parameters:
- NREG, 4, number of tri-state registers on the bus (2..16).
- WIDTH, 4, bus/data width in bits.
- SETTLE, 1, cycles OE is held low before sampling (>=1).
- GAP, 1, turnaround cycles with all OE high between consecutive enables (>=1).

Ports:
- CLK  input  1  rising-edge clock.
- CLR_N  input  1  asynchronous active-low reset.
- START  input  1  begin one scan of registers 0..NREG-1; sampled only in IDLE.
- BUS  input  WIDTH  shared tri-state bus, as seen by the reader.
- OE  output  NREG  per-register output enable; 1 = hi-Z, 0 = drive.
- DOUT  output  WIDTH  captured bus word.
- DIDX  output  clog2(NREG)  index of the register that DOUT came from.
- DVALID  output  1  DOUT/DIDX valid.
- DREADY  input  1  downstream accepts the word when DVALID&DREADY.
- BUSY  output  1  high in every state except IDLE.
- DONE  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
Reset (CLR_N=0, asynchronous, effective immediately):
- OE = all ones.
- DOUT = 0, DIDX = 0, DVALID = 0, BUSY = 0, DONE = 0.
- State = IDLE, index = 0, counters = 0.
- Reset mid-scan aborts the scan at once: OE returns to all ones with no glitch low. Nothing resumes after reset.

All outputs are registered. FSM states: IDLE, DRIVE, SAMPLE, HOLD, TURN, FIN.
- IDLE: START=1 -> DRIVE, index=0, OE[0]<=0.
- DRIVE: only OE[index]=0; count SETTLE cycles, then -> SAMPLE.
- SAMPLE: one cycle.
  - Capture BUS into DOUT and index into DIDX; DVALID<=1.
  - OE[index]<=1 on this same edge, so the bus is released before the handshake.
  - Next state -> HOLD.
- HOLD: DOUT/DIDX/DVALID stay stable until DVALID&DREADY.
  - On acceptance: DVALID<=0.
  - If index==NREG-1 -> FIN; else -> TURN.
- TURN: all OE=1 for GAP cycles, then index+1, OE[index+1]<=0 -> DRIVE.
- FIN: DONE=1 for one cycle -> IDLE. DONE and DVALID are never high together.

Rules and boundary conditions:
- START while BUSY is ignored (not queued). START held high through FIN starts a new scan from IDLE on the next cycle.
- Invariant: at most one OE bit is 0 in any cycle. Every cycle between two different low bits has all bits high.
- Latency, START edge to first DVALID: 1 + SETTLE cycles.
- Minimum per-word period with DREADY tied high: SETTLE + 2 + GAP cycles.
- DREADY low for any duration: the state holds in HOLD with the bus already released. No sample is lost or duplicated.
- Index never wraps past NREG-1. Words are delivered in index order 0..NREG-1, each exactly once per scan.
- BUS is sampled only in SAMPLE. Values in all other cycles, including X/Z, have no effect.

Decomposition:
- Shared package tribus_pkg:
  - state encoding constant/enum for the FSM.
  - OE_IDLE (all ones) helper constant.
  - index-width function clog2.
- One natural sub-module: tribus_oe_decode, a registered index->active-low one-hot with a global disable (all ones). It is the only driver of OE.
- The FSM, counters and output registers stay in the top module.

Test Plan:
- Reset/idle: hold CLR_N=0 for 3 cycles, then release with START=0 -> OE=4'b1111, DVALID=0, BUSY=0 for 10 cycles.
- Full scan, DREADY=1, four bus-side register models preloaded with 4'hA, 4'h3, 4'hF, 4'h0:
  - words (DIDX, DOUT) = (0,A), (1,3), (2,F), (3,0).
  - first DVALID 2 cycles after START; word period 4 cycles.
  - DONE one cycle after the last acceptance.
- Backpressure: DREADY=0 for 7 cycles on word 1 -> DOUT=4'h3 held stable, OE all ones during the stall, then the scan continues. Exactly 4 words are delivered.
- Contention monitor over a random DREADY pattern and 50 scans -> never two OE bits low; every low-to-low transition separated by at least GAP all-ones cycles.
- Async reset mid-DRIVE: pull CLR_N low between clock edges -> OE goes to all ones and DVALID to 0 before the next CLK edge. The next START restarts at DIDX=0.
- START ignored while busy: pulse START during word 2 -> no restart. Exactly one DONE, and 4 words in order.
